a2d_scan_ctrl: RTL

- Autonomous sequencer for the 16-bit SPI master talking to the ADC128S.
- Periodically scans a masked set of ADC channels, issuing the two-transaction convert/read pair per channel.
- Stores each 12-bit result in a per-channel register for the rest of the design to read.
- Sole owner of the SPI master's wrt/cmd inputs.

---
 rtl/a2d_scan_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/a2d_scan_ctrl.sv
// a2d_scan_ctrl: periodic scanner for an ADC128S behind a 16-bit SPI master.
// Each masked channel gets a convert/read transaction pair. The ADC is
// pipelined, so the word returned by the read transaction holds the sample
// for the channel addressed by the convert transaction. Results are kept in
// per-channel registers.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   IDLE     | scanning disabled or nothing to scan
//   CNV_REQ  | wrt strobe for the convert transaction of channel ch
//   CNV_WAIT | waiting for the SPI master to finish the convert
//   GAP      | one idle cycle so SS_n can deassert between frames
//   RD_REQ   | wrt strobe for the read transaction, same command
//   RD_WAIT  | waiting for the read word, which is then stored
//   NEXT     | choose the next masked channel, or finish the scan
//   WAIT_TMR | scan finished, waiting for the scan period to expire
module a2d_scan_ctrl #(
  parameter int NUM_CH      = 8,
  parameter int SCAN_PERIOD = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              done,
  input  logic [15:0]       rd_data,
  output logic              wrt,
  output logic [15:0]       cmd,
  input  logic [2:0]        res_sel,
  output logic [11:0]       res,
  output logic [NUM_CH-1:0] res_vld,
  output logic              scan_done,
  output logic              busy
);

  localparam int TW = $clog2(SCAN_PERIOD) + 1;

  typedef enum logic [2:0] {
    IDLE, CNV_REQ, CNV_WAIT, GAP, RD_REQ, RD_WAIT, NEXT, WAIT_TMR
  } state_t;

  state_t            state;
  logic [NUM_CH-1:0] mask_q;
  logic [2:0]        ch;
  logic [TW-1:0]     timer;
  logic              done_q;
  logic              done_rise;
  logic [11:0]       res_q [NUM_CH];
  logic [2:0]        first_ch;
  logic [2:0]        next_ch;
  logic              next_found;
  logic              start_ok;
  logic              period_up;
  logic              unused_rd_hi;

  assign done_rise    = done & ~done_q;
  assign start_ok     = en & (|ch_mask);
  assign period_up    = (timer >= TW'(SCAN_PERIOD - 1));
  assign busy         = (state != IDLE) && (state != WAIT_TMR);
  assign res          = res_q[res_sel];
  assign unused_rd_hi = ^rd_data[15:12];

  // Lowest channel of the live mask (scan start) and next higher channel of the latched mask.
  always_comb begin
    first_ch   = '0;
    next_ch    = '0;
    next_found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) first_ch = 3'(i);
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(ch))) begin
        next_ch    = 3'(i);
        next_found = 1'b1;
      end
    end
  end

  // Edge detector for the SPI done signal.
  always_ff @(posedge clk) begin
    if (rst) done_q <= 1'b0;
    else     done_q <= done;
  end

  // Scan sequencer with registered wrt/cmd/scan_done and result storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wrt       <= 1'b0;
      cmd       <= '0;
      scan_done <= 1'b0;
      res_vld   <= '0;
      mask_q    <= '0;
      ch        <= '0;
      timer     <= '0;
      for (int i = 0; i < NUM_CH; i++) res_q[i] <= '0;
    end else begin
      wrt       <= 1'b0;
      scan_done <= 1'b0;
      if ((state != IDLE) && (timer != '1)) timer <= timer + TW'(1);
      case (state)
        IDLE, WAIT_TMR: begin
          if (state == WAIT_TMR && !en) begin
            state <= IDLE;
          end else if (start_ok && (state == IDLE || period_up)) begin
            mask_q <= ch_mask;
            ch     <= first_ch;
            cmd    <= {2'b00, first_ch, 11'h000};
            timer  <= '0;
            wrt    <= 1'b1;
            state  <= CNV_REQ;
          end
        end
        CNV_REQ:  state <= CNV_WAIT;
        CNV_WAIT: if (done_rise) state <= GAP;
        GAP: begin
          wrt   <= 1'b1;
          state <= RD_REQ;
        end
        RD_REQ:   state <= RD_WAIT;
        RD_WAIT: begin
          if (done_rise) begin
            res_q[ch]   <= rd_data[11:0];
            res_vld[ch] <= 1'b1;
            state       <= NEXT;
          end
        end
        NEXT: begin
          // A disabled scan ends quietly after the pair in flight is stored.
          if (!en) begin
            state <= IDLE;
          end else if (next_found) begin
            ch    <= next_ch;
            cmd   <= {2'b00, next_ch, 11'h000};
            wrt   <= 1'b1;
            state <= CNV_REQ;
          end else begin
            scan_done <= 1'b1;
            state     <= WAIT_TMR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
